// File: rtl/wbuf_drain.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wbuf_drain : pops write-FIFO entries and issues them on a valid/ready bus |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module wbuf_drain #(
  parameter int W_ADDR    = 32,
  parameter int W_DATA    = 32,
  parameter int C_TIMEOUT = 255,
  parameter int W_CNT     = 16
) (
  input  logic                              sClk_i,
  input  logic                              snRst_i,
  input  logic                              Enable_i,
  input  logic [W_DATA/8+W_ADDR+W_DATA-1:0] FifoData_i,
  input  logic                              FifoEmpty_i,
  output logic                              FifoRead_o,
  output logic                              MemValid_o,
  output logic [W_ADDR-1:0]                 MemAddr_o,
  output logic [W_DATA-1:0]                 MemWdata_o,
  output logic [W_DATA/8-1:0]               MemWstrb_o,
  input  logic                              MemReady_i,
  input  logic                              Flush_i,
  output logic                              FlushDone_o,
  output logic                              Busy_o,
  output logic                              Error_o,
  output logic [W_ADDR-1:0]                 ErrAddr_o,
  input  logic                              ErrClr_i,
  output logic [W_CNT-1:0]                  WrCount_o
);

  localparam int          W_STRB     = W_DATA / 8;
  localparam logic [15:0] c_tmo_last = 16'(C_TIMEOUT - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [W_ADDR-1:0]   r_addr;
  logic [W_DATA-1:0]   r_wdata;
  logic [W_STRB-1:0]   r_wstrb;
  logic [15:0]         r_tmo_cnt;
  logic                r_err;
  logic [W_ADDR-1:0]   r_err_addr;
  logic [W_CNT-1:0]    r_wr_cnt;

  logic [W_STRB-1:0]   w_head_strb;
  logic [W_ADDR-1:0]   w_head_addr;
  logic [W_DATA-1:0]   w_head_data;
  logic                w_pop;
  logic                w_strb_nz;
  logic                w_fifo_rd;
  logic                w_capture;
  logic                w_done;
  logic                w_timeout;

  assign w_head_strb = FifoData_i[W_DATA+W_ADDR +: W_STRB];
  assign w_head_addr = FifoData_i[W_DATA +: W_ADDR];
  assign w_head_data = FifoData_i[0 +: W_DATA];
  assign w_pop       = ~FifoEmpty_i & (Enable_i | Flush_i);
  assign w_strb_nz   = |w_head_strb;

  always_comb begin
    w_state_nxt = r_state;
    w_fifo_rd   = 1'b0;
    w_capture   = 1'b0;
    w_done      = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pop) begin
          w_fifo_rd = 1'b1;
          if (w_strb_nz) begin
            w_capture   = 1'b1;
            w_state_nxt = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (MemReady_i) begin
          w_done = 1'b1;
          // Chain straight into the next entry so the bus sees no bubble.
          if (w_pop) begin
            w_fifo_rd = 1'b1;
            if (w_strb_nz) w_capture   = 1'b1;
            else           w_state_nxt = IDLE;
          end else begin
            w_state_nxt = IDLE;
          end
        end else if (r_tmo_cnt == c_tmo_last) begin
          w_timeout   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sClk_i or negedge snRst_i) begin
    if (!snRst_i) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_tmo_cnt  <= '0;
      r_err      <= 1'b0;
      r_err_addr <= '0;
      r_wr_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_capture) begin
        r_addr    <= w_head_addr;
        r_wdata   <= w_head_data;
        r_wstrb   <= w_head_strb;
        r_tmo_cnt <= '0;
      end else if (r_state == ISSUE && !MemReady_i && r_tmo_cnt != c_tmo_last) begin
        r_tmo_cnt <= r_tmo_cnt + 16'd1;
      end
      if (w_done) r_wr_cnt <= r_wr_cnt + 1'b1;
      // A clear beats a coincident timeout; only the first timeout is recorded.
      if (ErrClr_i) begin
        r_err      <= 1'b0;
        r_err_addr <= '0;
      end else if (w_timeout && !r_err) begin
        r_err      <= 1'b1;
        r_err_addr <= r_addr;
      end
    end
  end

  assign FifoRead_o  = w_fifo_rd;
  assign MemValid_o  = (r_state == ISSUE);
  assign MemAddr_o   = r_addr;
  assign MemWdata_o  = r_wdata;
  assign MemWstrb_o  = r_wstrb;
  assign FlushDone_o = Flush_i & FifoEmpty_i & (r_state == IDLE);
  assign Busy_o      = (r_state == ISSUE);
  assign Error_o     = r_err;
  assign ErrAddr_o   = r_err_addr;
  assign WrCount_o   = r_wr_cnt;

endmodule
`default_nettype wire

// File: tb/tb_wbuf_drain.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_wbuf_drain : directed self-checking bench for wbuf_drain               |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_wbuf_drain;

  logic        sClk_i = 1'b0;
  logic        snRst_i;
  logic        Enable_i;
  logic [67:0] FifoData_i;
  logic        FifoEmpty_i;
  logic        FifoRead_o;
  logic        MemValid_o;
  logic [31:0] MemAddr_o;
  logic [31:0] MemWdata_o;
  logic [3:0]  MemWstrb_o;
  logic        MemReady_i;
  logic        Flush_i;
  logic        FlushDone_o;
  logic        Busy_o;
  logic        Error_o;
  logic [31:0] ErrAddr_o;
  logic        ErrClr_i;
  logic [15:0] WrCount_o;

  int n_vec = 0;
  int n_err = 0;

  // Simple FIFO model: the initial block writes, the DUT's pop strobe advances the head.
  logic [67:0] fifo_mem [16];
  int          wr_ptr = 0;
  int          rd_ptr = 0;

  assign FifoEmpty_i = (rd_ptr == wr_ptr);
  assign FifoData_i  = fifo_mem[rd_ptr % 16];

  always @(posedge sClk_i) if (FifoRead_o) rd_ptr <= rd_ptr + 1;

  always #5 sClk_i = ~sClk_i;

  wbuf_drain #(
    .W_ADDR(32), .W_DATA(32), .C_TIMEOUT(4), .W_CNT(16)
  ) dut (
    .sClk_i(sClk_i), .snRst_i(snRst_i), .Enable_i(Enable_i),
    .FifoData_i(FifoData_i), .FifoEmpty_i(FifoEmpty_i), .FifoRead_o(FifoRead_o),
    .MemValid_o(MemValid_o), .MemAddr_o(MemAddr_o), .MemWdata_o(MemWdata_o),
    .MemWstrb_o(MemWstrb_o), .MemReady_i(MemReady_i), .Flush_i(Flush_i),
    .FlushDone_o(FlushDone_o), .Busy_o(Busy_o), .Error_o(Error_o),
    .ErrAddr_o(ErrAddr_o), .ErrClr_i(ErrClr_i), .WrCount_o(WrCount_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sClk_i);
    #1;
  endtask

  task automatic push(input logic [3:0] s, input logic [31:0] a, input logic [31:0] d);
    fifo_mem[wr_ptr % 16] = {s, a, d};
    wr_ptr = wr_ptr + 1;
  endtask

  initial begin
    snRst_i = 1'b0; Enable_i = 1'b0; MemReady_i = 1'b0; Flush_i = 1'b0; ErrClr_i = 1'b0;
    tick(); tick();
    chk("rst_valid", MemValid_o, 0);
    chk("rst_fiford", FifoRead_o, 0);
    chk("rst_addr", MemAddr_o, 0);
    chk("rst_wdata", MemWdata_o, 0);
    chk("rst_wstrb", MemWstrb_o, 0);
    chk("rst_err", Error_o, 0);
    chk("rst_erraddr", ErrAddr_o, 0);
    chk("rst_wrcnt", WrCount_o, 0);
    chk("rst_busy", Busy_o, 0);
    snRst_i = 1'b1;
    tick();

    // Single write, ready arrives in the third valid cycle
    Enable_i = 1'b1;
    push(4'hF, 32'h1000_0000, 32'hDEAD_BEEF);
    #1 chk("sw_pop", FifoRead_o, 1);
    tick();
    chk("sw_v1", MemValid_o, 1);
    chk("sw_addr1", MemAddr_o, 32'h1000_0000);
    chk("sw_data1", MemWdata_o, 32'hDEAD_BEEF);
    chk("sw_strb1", MemWstrb_o, 4'hF);
    chk("sw_nopop", FifoRead_o, 0);
    chk("sw_busy", Busy_o, 1);
    tick();
    chk("sw_v2", MemValid_o, 1);
    chk("sw_addr2", MemAddr_o, 32'h1000_0000);
    tick();
    MemReady_i = 1'b1;
    chk("sw_v3", MemValid_o, 1);
    chk("sw_data3", MemWdata_o, 32'hDEAD_BEEF);
    tick();
    MemReady_i = 1'b0;
    chk("sw_v4", MemValid_o, 0);
    chk("sw_cnt", WrCount_o, 1);
    chk("sw_idle", Busy_o, 0);

    // Back-to-back with ready tied high
    MemReady_i = 1'b1;
    push(4'hF, 32'h0, 32'h11); push(4'hF, 32'h4, 32'h22); push(4'hF, 32'h8, 32'h33);
    #1 chk("bb_pop0", FifoRead_o, 1);
    tick();
    chk("bb_v0", MemValid_o, 1); chk("bb_a0", MemAddr_o, 32'h0); chk("bb_pop1", FifoRead_o, 1);
    tick();
    chk("bb_v1", MemValid_o, 1); chk("bb_a1", MemAddr_o, 32'h4); chk("bb_pop2", FifoRead_o, 1);
    tick();
    chk("bb_v2", MemValid_o, 1); chk("bb_a2", MemAddr_o, 32'h8); chk("bb_pop3", FifoRead_o, 0);
    tick();
    chk("bb_end", MemValid_o, 0);
    chk("bb_cnt", WrCount_o, 4);
    MemReady_i = 1'b0;

    // Timeout (C_TIMEOUT=4): valid high 4 cycles, then error latched
    push(4'hF, 32'h2000_0010, 32'h55);
    tick();
    chk("to_v1", MemValid_o, 1);
    tick(); tick(); tick();
    chk("to_v4", MemValid_o, 1);
    chk("to_err_pre", Error_o, 0);
    tick();
    chk("to_v5", MemValid_o, 0);
    chk("to_err", Error_o, 1);
    chk("to_erraddr", ErrAddr_o, 32'h2000_0010);
    chk("to_cnt", WrCount_o, 4);
    push(4'hF, 32'h30, 32'h66);
    tick(); tick(); tick(); tick(); tick();
    chk("to2_v", MemValid_o, 0);
    chk("to2_err", Error_o, 1);
    chk("to2_erraddr_held", ErrAddr_o, 32'h2000_0010);
    ErrClr_i = 1'b1;
    tick();
    ErrClr_i = 1'b0;
    chk("clr_err", Error_o, 0);
    chk("clr_erraddr", ErrAddr_o, 0);
    // Clear coincident with a new timeout wins
    push(4'hF, 32'h40, 32'h77);
    tick(); tick(); tick(); tick();
    ErrClr_i = 1'b1;
    tick();
    ErrClr_i = 1'b0;
    chk("clrpri_v", MemValid_o, 0);
    chk("clrpri_err", Error_o, 0);
    chk("clrpri_erraddr", ErrAddr_o, 0);

    // Flush overrides Enable_i=0
    Enable_i = 1'b0;
    push(4'hF, 32'h100, 32'hA0); push(4'hF, 32'h104, 32'hA4);
    #1 chk("fl_nopop", FifoRead_o, 0);
    tick();
    chk("fl_noissue", MemValid_o, 0);
    Flush_i = 1'b1; MemReady_i = 1'b1;
    #1 chk("fl_pop", FifoRead_o, 1);
    chk("fl_done0", FlushDone_o, 0);
    tick();
    chk("fl_a0", MemAddr_o, 32'h100); chk("fl_done1", FlushDone_o, 0);
    tick();
    chk("fl_a1", MemAddr_o, 32'h104); chk("fl_done2", FlushDone_o, 0);
    tick();
    chk("fl_done3", FlushDone_o, 1);
    chk("fl_cnt", WrCount_o, 6);
    Flush_i = 1'b0;
    #1 chk("fl_done_off", FlushDone_o, 0);

    // Zero-strobe entry between two valid ones
    Enable_i = 1'b1;
    push(4'hF, 32'h200, 32'hB0); push(4'h0, 32'h204, 32'hB4); push(4'h3, 32'h208, 32'hB8);
    tick();
    chk("zs_a0", MemAddr_o, 32'h200); chk("zs_popz", FifoRead_o, 1);
    tick();
    chk("zs_gap", MemValid_o, 0); chk("zs_pop2", FifoRead_o, 1);
    tick();
    chk("zs_a2", MemAddr_o, 32'h208); chk("zs_s2", MemWstrb_o, 4'h3);
    tick();
    chk("zs_end", MemValid_o, 0);
    chk("zs_cnt", WrCount_o, 8);

    // Reset mid-ISSUE
    MemReady_i = 1'b0;
    push(4'hF, 32'h300, 32'hC0);
    tick();
    chk("rm_v", MemValid_o, 1);
    #2 snRst_i = 1'b0;
    #1;
    chk("rm_v0", MemValid_o, 0);
    chk("rm_addr", MemAddr_o, 0);
    chk("rm_cnt", WrCount_o, 0);
    chk("rm_busy", Busy_o, 0);
    tick();
    snRst_i = 1'b1;
    MemReady_i = 1'b1;
    push(4'hF, 32'h400, 32'hD0);
    tick();
    chk("rm_resume_a", MemAddr_o, 32'h400);
    chk("rm_resume_v", MemValid_o, 1);
    tick();
    chk("rm_resume_cnt", WrCount_o, 1);
    chk("rm_resume_idle", MemValid_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
